// File: rtl/phase_sequencer.sv
// phase_sequencer: programmable machine-cycle phase generator for the GCore datapath.
// Steps a phase index from 0 up to last_phase and emits a registered strobe
// pattern per phase from a writable table. Supports stall, single-step,
// early termination (skip) and a wrapping completed-cycle counter.
module phase_sequencer #(
  parameter int PHASE_W = 3,
  parameter int NSTB    = 6,
  parameter int CNT_W   = 16
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               ena,
  input  logic               stall,
  input  logic               step_mode,
  input  logic               step,
  input  logic               skip,
  input  logic [PHASE_W-1:0] last_phase,
  input  logic               cfg_we,
  input  logic [PHASE_W-1:0] cfg_addr,
  input  logic [NSTB-1:0]    cfg_data,
  output logic [NSTB-1:0]    strobe,
  output logic [PHASE_W-1:0] phase,
  output logic               cycle_start,
  output logic               cycle_done,
  output logic [CNT_W-1:0]   cycle_count
);

  localparam int NPHASE = 2 ** PHASE_W;

  // Power-on strobe table: bit0 pc, 1 opram, 2 mem, 3 acc, 4 alu, 5 out.
  function automatic logic [NSTB-1:0] default_entry(input int idx);
    logic [7:0] v;
    case (idx)
      0:       v = 8'h01;
      1:       v = 8'h02;
      2:       v = 8'h0C;
      3:       v = 8'h10;
      4:       v = 8'h0C;
      7:       v = 8'h20;
      default: v = 8'h00;
    endcase
    return NSTB'(v);
  endfunction

  logic [NSTB-1:0]    tbl [NPHASE];
  logic               adv;
  logic               at_last;
  logic [PHASE_W-1:0] phase_next;

  // Advance qualifier and next-phase selection; an index beyond last_phase
  // (last_phase lowered mid-cycle) behaves like skip so the final pattern is kept.
  always_comb begin
    adv        = ena & ~stall & (step_mode ? step : 1'b1);
    at_last    = (phase == last_phase);
    phase_next = phase + PHASE_W'(1);
    if (at_last) begin
      phase_next = '0;
    end else if (skip || (phase > last_phase)) begin
      phase_next = last_phase;
    end
  end

  // Strobe table: reloaded on reset, otherwise writable regardless of ena/stall.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      for (int i = 0; i < NPHASE; i++) begin
        tbl[i] <= default_entry(i);
      end
    end else if (cfg_we) begin
      tbl[cfg_addr] <= cfg_data;
    end
  end

  // Sequencing state: the strobe reads the pre-edge table, so a same-edge
  // write to the emitted entry only shows on the next visit.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      phase       <= '0;
      strobe      <= '0;
      cycle_start <= 1'b0;
      cycle_done  <= 1'b0;
      cycle_count <= '0;
    end else begin
      cycle_start <= adv & (phase == '0);
      cycle_done  <= adv & at_last;
      if (adv) begin
        strobe <= tbl[phase];
        phase  <= phase_next;
        if (at_last) begin
          cycle_count <= cycle_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: directed steps from the test plan
// plus a randomized section, all checked against a behavioural model.
module tb_phase_sequencer;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        ena;
  logic        stall;
  logic        step_mode;
  logic        step;
  logic        skip;
  logic [2:0]  last_phase;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [5:0]  cfg_data;
  logic [5:0]  strobe;
  logic [2:0]  phase;
  logic        cycle_start;
  logic        cycle_done;
  logic [15:0] cycle_count;

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  logic [5:0]  m_tbl [8];
  logic [5:0]  m_strobe;
  int          m_phase;
  logic        m_start;
  logic        m_done;
  logic [15:0] m_count;

  logic [5:0] def_tbl [8] = '{6'h01, 6'h02, 6'h0C, 6'h10, 6'h0C, 6'h00, 6'h00, 6'h20};
  logic [5:0] exp_run [9] = '{6'h01, 6'h02, 6'h0C, 6'h10, 6'h0C, 6'h00, 6'h00, 6'h20, 6'h01};
  logic [5:0] exp_lp3 [4] = '{6'h11, 6'h22, 6'h04, 6'h08};

  phase_sequencer #(.PHASE_W(3), .NSTB(6), .CNT_W(16)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .ena         (ena),
    .stall       (stall),
    .step_mode   (step_mode),
    .step        (step),
    .skip        (skip),
    .last_phase  (last_phase),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .strobe      (strobe),
    .phase       (phase),
    .cycle_start (cycle_start),
    .cycle_done  (cycle_done),
    .cycle_count (cycle_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one rising edge, using the inputs present before it.
  task automatic model_step();
    bit a;
    int lp;
    if (!rst) begin
      m_phase  = 0;
      m_strobe = '0;
      m_start  = 1'b0;
      m_done   = 1'b0;
      m_count  = '0;
      for (int i = 0; i < 8; i++) m_tbl[i] = def_tbl[i];
    end else begin
      a  = ena && !stall && (!step_mode || step);
      lp = int'(last_phase);
      if (a) begin
        m_strobe = m_tbl[m_phase];
        m_start  = (m_phase == 0);
        m_done   = (m_phase == lp);
        if (m_done) m_count = m_count + 16'd1;
        if (m_phase == lp)              m_phase = 0;
        else if (skip || m_phase > lp)  m_phase = lp;
        else                            m_phase = m_phase + 1;
      end else begin
        m_start = 1'b0;
        m_done  = 1'b0;
      end
      if (cfg_we) m_tbl[cfg_addr] = cfg_data;
    end
  endtask

  task automatic check_model();
    chk("model_strobe", 32'(strobe), 32'(m_strobe));
    chk("model_phase", 32'(phase), 32'(m_phase));
    chk("model_cycle_start", 32'(cycle_start), 32'(m_start));
    chk("model_cycle_done", 32'(cycle_done), 32'(m_done));
    chk("model_cycle_count", 32'(cycle_count), 32'(m_count));
  endtask

  task automatic tick(input bit full_check);
    @(posedge clk_in);
    model_step();
    #1;
    if (full_check) check_model();
  endtask

  // Free-run until the model reaches phase p, bounded by budget clocks.
  task automatic wait_phase(input int p, input int budget);
    int n = 0;
    while (m_phase != p && n < budget) begin
      tick(1);
      n++;
    end
    chk("wait_phase_reached", 32'(phase), 32'(p));
  endtask

  initial begin
    int p0;
    logic [15:0] c0;

    rst = 1'b0; ena = 1'b0; stall = 1'b0; step_mode = 1'b0; step = 1'b0;
    skip = 1'b0; last_phase = 3'd7; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    tick(1);
    tick(1);
    chk("reset_strobe", 32'(strobe), 32'h0);
    chk("reset_phase", 32'(phase), 32'h0);
    chk("reset_count", 32'(cycle_count), 32'h0);

    // Free run with default table
    rst = 1'b1; ena = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick(1);
      chk("run_strobe", 32'(strobe), 32'(exp_run[k]));
      chk("run_start", 32'(cycle_start), 32'((k == 0 || k == 8) ? 1 : 0));
      chk("run_done", 32'(cycle_done), 32'((k == 7) ? 1 : 0));
    end
    chk("run_count_after_cycle", 32'(cycle_count), 32'd1);

    // Stall while 0x0C (phase 2 pattern) is shown and phase=3
    tick(1);
    tick(1);
    chk("stall_pre_strobe", 32'(strobe), 32'h0C);
    chk("stall_pre_phase", 32'(phase), 32'd3);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      chk("stall_hold_strobe", 32'(strobe), 32'h0C);
      chk("stall_hold_count", 32'(cycle_count), 32'd1);
    end
    stall = 1'b0;
    tick(1);
    chk("stall_release_strobe", 32'(strobe), 32'h10);

    // Skip sampled on the edge that emits 0x10
    wait_phase(3, 16);
    skip = 1'b1;
    tick(1);
    chk("skip_strobe_10", 32'(strobe), 32'h10);
    chk("skip_phase_to_last", 32'(phase), 32'd7);
    skip = 1'b0;
    tick(1);
    chk("skip_strobe_20", 32'(strobe), 32'h20);
    chk("skip_done", 32'(cycle_done), 32'd1);
    tick(1);
    chk("skip_wrap_strobe", 32'(strobe), 32'h01);
    chk("skip_wrap_start", 32'(cycle_start), 32'd1);

    // Single-step: one pattern per pulse, full cycle in 8 pulses
    step_mode = 1'b1;
    p0 = m_phase;
    c0 = m_count;
    for (int k = 0; k < 8; k++) begin
      step = 1'b1;
      tick(1);
      step = 1'b0;
      for (int j = 0; j < 4; j++) tick(1);
    end
    chk("step_cycle_phase", 32'(phase), 32'(p0));
    chk("step_cycle_count", 32'(cycle_count), 32'(c0 + 16'd1));
    step_mode = 1'b0;

    // Table writes while frozen, then a 4-phase cycle
    ena = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cfg_we = 1'b1; cfg_addr = 3'(k); cfg_data = exp_lp3[k];
      tick(1);
    end
    cfg_we = 1'b0;
    last_phase = 3'd3;
    ena = 1'b1;
    wait_phase(0, 16);
    for (int k = 0; k < 8; k++) begin
      tick(1);
      chk("lp3_strobe", 32'(strobe), 32'(exp_lp3[k % 4]));
      chk("lp3_done", 32'(cycle_done), 32'((k % 4 == 3) ? 1 : 0));
    end
    tick(1);
    cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = 6'h33;
    tick(1);
    chk("same_edge_write_old", 32'(strobe), 32'h22);
    cfg_we = 1'b0;
    tick(1);
    tick(1);
    tick(1);
    tick(1);
    chk("same_edge_write_new", 32'(strobe), 32'h33);

    // Randomized sequencing against the model
    for (int k = 0; k < 500; k++) begin
      rst       = ($urandom_range(0, 99) != 0);
      ena       = ($urandom_range(0, 9) != 0);
      stall     = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 15) == 0) step_mode = ~step_mode;
      step      = 1'($urandom_range(0, 1));
      skip      = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) last_phase = 3'($urandom_range(0, 7));
      cfg_we    = ($urandom_range(0, 7) == 0);
      cfg_addr  = 3'($urandom_range(0, 7));
      cfg_data  = 6'($urandom_range(0, 63));
      tick(1);
    end
    rst = 1'b1; ena = 1'b1; stall = 1'b0; step_mode = 1'b0; step = 1'b0;
    skip = 1'b0; cfg_we = 1'b0; last_phase = 3'd7;

    // Reset mid-cycle overrides a table write
    tick(1);
    tick(1);
    tick(1);
    rst = 1'b0; cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 6'h3F;
    tick(1);
    chk("midreset_strobe", 32'(strobe), 32'h0);
    chk("midreset_phase", 32'(phase), 32'h0);
    chk("midreset_count", 32'(cycle_count), 32'h0);

    // last_phase=0: table[0] every clock, start and done together; then wrap
    rst = 1'b1; cfg_we = 1'b0; last_phase = 3'd0;
    tick(1);
    chk("lp0_strobe_default", 32'(strobe), 32'h01);
    chk("lp0_start", 32'(cycle_start), 32'd1);
    chk("lp0_done", 32'(cycle_done), 32'd1);
    chk("lp0_count", 32'(cycle_count), 32'd1);
    for (int k = 0; k < 65534; k++) tick(0);
    chk("wrap_count_max", 32'(cycle_count), 32'hFFFF);
    tick(1);
    chk("wrap_count_zero", 32'(cycle_count), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
